fetch_unit: RTL

- IF stage plus IF/ID pipeline register for the RV64I-Zba five-stage pipeline.
- Owns the fetch PC and issues requests to instruction memory through a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a small FIFO and presents {Instr_D, PC_D, PCPlus4_D} to decode.
- Obeys Stall_F/Stall_D/Flush_D from the hazard unit, and PCSrc_E/PCTarget_E redirects from execute.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: issues imem requests from PC_F, buffers returned
// instructions in a small FIFO and feeds decode under hazard-unit control.
module fetch_unit #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2,
    parameter int              MAX_OUT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall_F,
    input  logic            Stall_D,
    input  logic            Flush_D,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     Instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PCPlus4_D,
    output logic            Valid_D
);
    localparam int          PW  = $clog2(BUF_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fifo_pc_mem    [BUF_DEPTH];
    logic [31:0]     fifo_instr_mem [BUF_DEPTH];
    logic [XLEN-1:0] pcq_mem        [BUF_DEPTH];
    ptr_t            fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    ptr_t            pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    cnt_t            fifo_cnt_q, fifo_cnt_d, out_q, out_d, kill_q, kill_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic            id_valid_q, id_valid_d;
    logic            issue, rsp_kill, fifo_push, fifo_pop;
    sum_t            reserved;

    // A pop this cycle frees its slot at the same edge, so it counts as credit;
    // without it a 2-entry buffer could not sustain one instruction per cycle.
    always_comb begin
        fifo_pop       = !Flush_D && !Stall_D && (fifo_cnt_q != '0);
        reserved       = sum_t'(fifo_cnt_q) + sum_t'(out_q) - sum_t'(fifo_pop);
        imem_req_valid = !rst && !Stall_F && !PCSrc_E
                         && (reserved < sum_t'(BUF_DEPTH)) && (out_q < cnt_t'(MAX_OUT));
        imem_req_addr  = pc_q;
        issue          = imem_req_valid && imem_req_ready;
        rsp_kill       = imem_rsp_valid && (kill_q != '0);
        fifo_push      = imem_rsp_valid && !rsp_kill && !PCSrc_E;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pc_d       = pc_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + cnt_t'(fifo_push) - cnt_t'(fifo_pop);
        out_d      = out_q + cnt_t'(issue) - cnt_t'(imem_rsp_valid);
        kill_d     = kill_q - cnt_t'(rsp_kill);
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;

        if (issue) begin
            pc_d     = pc_q + XLEN'(4);
            pcq_wr_d = pcq_wr_q + ptr_t'(1);
        end
        if (imem_rsp_valid) pcq_rd_d  = pcq_rd_q + ptr_t'(1);
        if (fifo_push)      fifo_wr_d = fifo_wr_q + ptr_t'(1);
        if (fifo_pop)       fifo_rd_d = fifo_rd_q + ptr_t'(1);

        // Every request still in flight after this edge belongs to the old path.
        if (PCSrc_E) begin
            pc_d       = PCTarget_E & ~XLEN'(3);
            fifo_rd_d  = fifo_wr_q;
            fifo_wr_d  = fifo_wr_q;
            fifo_cnt_d = '0;
            kill_d     = out_q - cnt_t'(imem_rsp_valid);
        end

        if (Flush_D || (!Stall_D && !fifo_pop)) begin
            id_instr_d = NOP;
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end else if (fifo_pop) begin
            id_instr_d = fifo_instr_mem[fifo_rd_q];
            id_pc_d    = fifo_pc_mem[fifo_rd_q];
            id_pc4_d   = fifo_pc_mem[fifo_rd_q] + XLEN'(4);
            id_valid_d = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            out_q      <= '0;
            kill_q     <= '0;
            id_instr_q <= NOP;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_q      <= out_d;
            kill_q     <= kill_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    // NOTE: storage arrays are not reset; the counters and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (issue) pcq_mem[pcq_wr_q] <= pc_q;
        if (fifo_push) begin
            fifo_pc_mem[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
            fifo_instr_mem[fifo_wr_q] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && (fifo_cnt_q == cnt_t'(BUF_DEPTH))));

    assign Instr_D   = id_instr_q;
    assign PC_D      = id_pc_q;
    assign PCPlus4_D = id_pc4_q;
    assign Valid_D   = id_valid_q;
endmodule
